// File: rtl/if_icache.sv
// Direct-mapped instruction cache in the fetch stage: one-word lines, hits served combinationally.
// Latency: hit 0 cycles; miss issues inst_req the next cycle and bypasses the returned word on inst_done.
// Backpressure: if_stall holds the PC source while a miss is outstanding; flush_i abandons the miss.
module if_icache #(
    parameter int ADDR_W = 32,
    parameter int IDX_W  = 7,
    parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] inst_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              if_stall,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr_o,
    input  logic [ADDR_W-1:0] inst_i,
    input  logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_done
);

    localparam int LINES = 1 << IDX_W;

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t            state, state_nxt;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tag_arr  [LINES];
    logic [ADDR_W-1:0] data_arr [LINES];

    logic [ADDR_W-1:0] miss_addr, miss_addr_nxt, inst_addr_nxt;
    logic              req_nxt;
    logic              fill;
    logic [IDX_W-1:0]  idx, fill_idx;
    logic [TAG_W-1:0]  tag;
    logic              hit, bypass;

    assign idx      = pc_i[IDX_W+1:2];
    assign tag      = pc_i[ADDR_W-1:IDX_W+2];
    assign fill_idx = miss_addr[IDX_W+1:2];
    assign hit      = valid[idx] && (tag_arr[idx] == tag);
    // The returned word is forwarded only if it matches what the PC asks for right now.
    assign bypass   = (state == WAIT) && inst_done && (inst_pc == pc_i);

    always_comb begin
        inst_o   = '0;
        pc_o     = '0;
        if_stall = 1'b0;
        if (!rst) begin
            if (hit) begin
                inst_o = data_arr[idx];
                pc_o   = pc_i;
            end else if (bypass) begin
                inst_o = inst_i;
                pc_o   = pc_i;
            end else begin
                if_stall = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        miss_addr_nxt = miss_addr;
        inst_addr_nxt = inst_addr_o;
        req_nxt       = inst_req;
        fill          = 1'b0;
        case (state)
            IDLE: begin
                if (!hit && !flush_i) begin
                    state_nxt     = WAIT;
                    miss_addr_nxt = {pc_i[ADDR_W-1:2], 2'b00};
                    inst_addr_nxt = {pc_i[ADDR_W-1:2], 2'b00};
                    req_nxt       = 1'b1;
                end
            end
            WAIT: begin
                // An accepted response wins over a simultaneous flush so the line still fills.
                if (inst_done && (inst_pc == miss_addr)) begin
                    fill      = 1'b1;
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end else if (flush_i) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            miss_addr   <= '0;
            inst_addr_o <= '0;
            inst_req    <= 1'b0;
            valid       <= '0;
        end else begin
            state       <= state_nxt;
            miss_addr   <= miss_addr_nxt;
            inst_addr_o <= inst_addr_nxt;
            inst_req    <= req_nxt;
            if (fill) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill && !rst) begin
            tag_arr[fill_idx]  <= miss_addr[ADDR_W-1:IDX_W+2];
            data_arr[fill_idx] <= inst_i;
        end
    end

endmodule

// File: tb/tb_if_icache.sv
// Scoreboarded bench for if_icache: directed test-plan sequences followed by random fetch/memory traffic.
module tb_if_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        flush_i;
    logic [31:0] inst_o, pc_o;
    logic        if_stall;
    logic        inst_req;
    logic [31:0] inst_addr_o;
    logic [31:0] inst_i, inst_pc;
    logic        inst_done;

    always #5 clk = ~clk;

    if_icache dut (
        .clk        (clk),
        .rst        (rst),
        .pc_i       (pc_i),
        .flush_i    (flush_i),
        .inst_o     (inst_o),
        .pc_o       (pc_o),
        .if_stall   (if_stall),
        .inst_req   (inst_req),
        .inst_addr_o(inst_addr_o),
        .inst_i     (inst_i),
        .inst_pc    (inst_pc),
        .inst_done  (inst_done)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        stall;
        logic        req;
        logic [31:0] addr;
        bit          chk_reg;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: which aligned address each index currently holds, and the outstanding miss.
    logic [31:0] line_of[int];
    logic [31:0] word_of[int];
    bit          m_wait  = 0;
    logic [31:0] m_addr  = '0;
    bit          m_known = 0;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % 128);
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0000_0013 : {a[15:0] ^ 16'hC0DE, ~a[15:0]};
    endfunction

    function automatic logic [31:0] rnd_addr();
        return ($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 2);
    endfunction

    task automatic cycle(input logic r, input logic [31:0] p, input logic f,
                         input logic d, input logic [31:0] ipc, input logic [31:0] iw);
        exp_t        e;
        bit          hit;
        logic [31:0] al;
        @(posedge clk);
        #1;
        rst = r; pc_i = p; flush_i = f; inst_done = d; inst_pc = ipc; inst_i = iw;
        al  = {p[31:2], 2'b00};
        hit = line_of.exists(idx_of(p)) && (line_of[idx_of(p)] == al);
        e.req = m_wait; e.addr = m_addr; e.chk_reg = m_known;
        if (r) begin
            e.inst = '0; e.pc = '0; e.stall = 1'b0;
        end else if (hit) begin
            e.inst = word_of[idx_of(p)]; e.pc = p; e.stall = 1'b0;
        end else if (m_wait && d && ipc == p) begin
            e.inst = iw; e.pc = p; e.stall = 1'b0;
        end else begin
            e.inst = '0; e.pc = '0; e.stall = 1'b1;
        end
        exp_q.push_back(e);
        if (r) begin
            line_of.delete(); word_of.delete();
            m_wait = 0; m_addr = '0; m_known = 1;
        end else if (!m_wait) begin
            if (!hit && !f) begin
                m_wait = 1; m_addr = al;
            end
        end else if (d && ipc == m_addr) begin
            line_of[idx_of(m_addr)] = m_addr;
            word_of[idx_of(m_addr)] = iw;
            m_wait = 0;
        end else if (f) begin
            m_wait = 0;
        end
    endtask

    task automatic serve(input logic [31:0] p, input int lat);
        cycle(0, p, 0, 0, 0, 0);
        if (m_wait) begin
            repeat (lat) cycle(0, p, 0, 0, 0, 0);
            cycle(0, p, 0, 1, p, mem_word(p));
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("inst_o", inst_o, e.inst);
                chk("pc_o", pc_o, e.pc);
                chk("if_stall", {31'b0, if_stall}, {31'b0, e.stall});
                if (e.chk_reg) begin
                    chk("inst_req", {31'b0, inst_req}, {31'b0, e.req});
                    chk("inst_addr_o", inst_addr_o, e.addr);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] cur_pc, ipc;
        logic        r, f, d;
        bit          was;
        int          lat;
        rst = 1'b1; pc_i = '0; flush_i = 1'b0; inst_done = 1'b0; inst_pc = '0; inst_i = '0;

        repeat (2) cycle(1, 32'h0, 0, 0, 0, 0);
        serve(32'h0, 3);                              // cold miss, done 3 cycles after request
        serve(32'h0, 3);                              // hit
        serve(32'h4, 1);
        serve(32'h204, 2);                            // conflicts with 0x4 at idx 1
        serve(32'h4, 0);
        cycle(0, 32'h100, 0, 0, 0, 0);                // flush cancels miss on 0x100
        cycle(0, 32'h100, 0, 0, 0, 0);
        cycle(0, 32'h200, 1, 0, 0, 0);
        cycle(0, 32'h200, 0, 0, 0, 0);
        cycle(0, 32'h200, 0, 1, 32'h100, mem_word(32'h100));
        cycle(0, 32'h200, 0, 1, 32'h200, mem_word(32'h200));
        serve(32'h100, 1);
        cycle(0, 32'h40, 0, 0, 0, 0);                 // mismatched response
        cycle(0, 32'h40, 0, 1, 32'h44, mem_word(32'h44));
        cycle(0, 32'h40, 0, 0, 0, 0);
        cycle(0, 32'h40, 0, 1, 32'h40, mem_word(32'h40));
        cycle(0, 32'h80, 0, 0, 0, 0);                 // reset mid-miss then late response
        cycle(0, 32'h80, 0, 0, 0, 0);
        cycle(1, 32'h80, 0, 0, 0, 0);
        cycle(0, 32'h80, 0, 1, 32'h80, mem_word(32'h80));
        cycle(0, 32'h80, 0, 1, 32'h80, mem_word(32'h80));
        serve(32'h0, 1);
        serve(32'h4, 0);

        cur_pc = 32'h0;
        lat    = 0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            f = 1'b0; d = 1'b0; ipc = '0;
            if (m_wait) begin
                if ($urandom_range(0, 9) == 0) begin
                    f = 1'b1; cur_pc = rnd_addr();
                end else if ($urandom_range(0, 11) == 0) begin
                    cur_pc = rnd_addr();
                end
                if (lat == 0) begin
                    d = 1'b1; ipc = m_addr;
                end else if ($urandom_range(0, 7) == 0) begin
                    d = 1'b1; ipc = rnd_addr();
                end
            end else begin
                if ($urandom_range(0, 2) == 0) cur_pc = rnd_addr();
                if ($urandom_range(0, 19) == 0) f = 1'b1;
                if ($urandom_range(0, 7) == 0) begin
                    d = 1'b1; ipc = rnd_addr();
                end
            end
            was = m_wait;
            cycle(r, cur_pc, f, d, ipc, mem_word(ipc));
            if (!was && m_wait) lat = $urandom_range(0, 3);
            else if (m_wait && lat > 0) lat--;
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_icache.md
Name: if_icache

Overview:
- Instruction-fetch stage with a parametrised direct-mapped instruction cache between the PC register and the memory controller.
- Hits return the instruction combinationally in the same cycle with no stall.
- Misses run a request/fill handshake with the memory controller, then bypass the returned word to the fetch output.
- Adds a flush input that cancels an outstanding miss on a redirect (branch or jump).

Parameters:
- ADDR_W, 32, byte-address and instruction width.
- IDX_W, 7, index bits; the cache holds 2^IDX_W one-word lines.
- TAG_W, ADDR_W-IDX_W-2, tag bits (derived; do not override).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset; one clock; all state updates on posedge clk.
- pc_i  in  ADDR_W  fetch address from pc_reg; word-aligned, bits [1:0] ignored.
- flush_i  in  1  redirect; cancels any outstanding miss.
- inst_o  out  ADDR_W  fetched instruction to if_id; zero when not valid.
- pc_o  out  ADDR_W  PC of inst_o; zero when not valid.
- if_stall  out  1  high while pc_i cannot be served this cycle.
- inst_req  out  1  fetch request to mem_ctrl.
- inst_addr_o  out  ADDR_W  request address; stable while inst_req is high.
- inst_i  in  ADDR_W  returned instruction word.
- inst_pc  in  ADDR_W  address of the returned word.
- inst_done  in  1  inst_i/inst_pc are valid this cycle.

Behaviour:
- Address split: idx = pc_i[IDX_W+1:2]; tag = pc_i[ADDR_W-1:IDX_W+2].
- Storage per line: valid bit, tag, data word. Only valid bits need a reset.
- Lookup is combinational: hit = valid[idx] && tag_arr[idx]==tag.
- State machine IDLE/WAIT. Registered: state, miss_addr, inst_req, inst_addr_o.
- Reset:
  - All valid bits cleared; state=IDLE; inst_req=0; inst_addr_o=0; miss_addr=0.
  - Combinational outputs while rst=1: inst_o=0, pc_o=0, if_stall=0.
- Output rule (every cycle, rst=0):
  - Output path: if hit, or (state==WAIT && inst_done && inst_pc==pc_i), then inst_o = cached word or inst_i (bypass), pc_o = pc_i, if_stall = 0.
  - Otherwise inst_o = 0, pc_o = 0, if_stall = 1.
  - flush_i does not mask the output path; the PC source drives the new pc_i.
- IDLE:
  - On a miss with flush_i=0: next state WAIT; miss_addr, inst_addr_o <= {pc_i[ADDR_W-1:2],2'b00}; inst_req <= 1.
  - Earliest request is 1 cycle after the miss is seen.
  - inst_done in IDLE is ignored; no fill.
- WAIT:
  - inst_req is held at 1 and inst_addr_o held stable.
  - Response accepted only when inst_done && inst_pc==miss_addr. On accept: write valid/tag/data at miss_addr's index (overwriting any prior line); inst_req <= 0; next state IDLE.
  - A response with a mismatched inst_pc is ignored; stay in WAIT.
- Flush in WAIT:
  - flush_i=1 without an accepted response: state <= IDLE, inst_req <= 0, no fill.
  - A later response for the cancelled address is ignored (state is IDLE).
  - A new miss can be issued from the cycle after the flush.
- Simultaneous flush and accepted response in WAIT: the fill completes (the line is valid), then state <= IDLE.
- pc_i changes during WAIT (without flush): the miss continues to completion and fills miss_addr. Output follows the current pc_i.
- Back-to-back misses: the minimum request-free gap is 1 cycle (IDLE re-entry). The request for the next miss rises the cycle after the fill.
- Reset during WAIT: state returns to IDLE, request drops, valid bits clear; any late inst_done is ignored.
- Conflict: two addresses with the same idx and different tags evict each other; no associativity.

Test Plan:
- Cold miss:
  - Stimulus: reset 2 cycles, then pc_i=0x0000_0000, mem returns inst_i=0x0000_0013, inst_pc=0 with inst_done 3 cycles after the request.
  - Required: if_stall=1 until the done cycle; the done cycle gives inst_o=0x13, pc_o=0, if_stall=0; inst_req drops the next cycle.
- Hit:
  - Stimulus: after the cold miss, re-present pc_i=0x0.
  - Required: inst_o=0x13 the same cycle, inst_req stays 0, no memory traffic.
- Conflict eviction (IDX_W=7):
  - Stimulus: fill 0x0000_0004, then fetch 0x0000_0204 (same idx 1, new tag).
  - Required: 0x204 misses and refills; then 0x004 misses again.
- Flush cancels miss:
  - Stimulus: miss on 0x100; flush_i pulsed 1 cycle in WAIT with pc_i -> 0x200; stale inst_done with inst_pc=0x100 arrives 2 cycles later.
  - Required: no fill at idx 0x40; request for 0x200 issued; 0x100 misses when re-fetched.
- Mismatched response:
  - Stimulus: in WAIT for 0x40, inst_done with inst_pc=0x44.
  - Required: ignored; still stalled; inst_req=1 with inst_addr_o=0x40.
- Reset mid-miss:
  - Stimulus: assert rst while in WAIT, then a late inst_done.
  - Required: inst_req=0 the cycle after rst; all lines invalid; the late response causes no fill.
